dm_wait_responder: RTL and testbench
====================================

Name: dm_wait_responder

Overview:
- Data-memory responder on the processor's data-memory strobe interface (chip enable, output enable, write enable; all active low).
- Decodes the strobes into read/write transactions and inserts a configurable number of wait states on an internal RAM array.
- Stalls the processor through its hold input until each access completes, then returns read data.
- Sits between the processor core and on-chip data RAM; used to model and serve slow memory.

Parameters:
- DATA_WIDTH, 16, data word width.
- ADDRRAM_WIDTH, 10, address width.
- DEPTH, 1024, number of implemented words; must be ≤ 2^ADDRRAM_WIDTH.
- WAIT_STATES, 2, extra stall cycles per access; legal range 0..15.

Ports:
- clock_i  in  1  system clock; rising edge.
- nreset_i  in  1  asynchronous active-low reset.
- addr_i  in  ADDRRAM_WIDTH  word address from the processor.
- data_i  in  DATA_WIDTH  write data from the processor.
- dm_CEn_i  in  1  chip enable, active low.
- dm_OEn_i  in  1  output enable (read), active low.
- dm_WEn_i  in  1  write enable, active low.
- hold_o  out  1  stall request to the processor; high = processor must freeze.
- data_o  out  DATA_WIDTH  registered read data.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle error pulse, coincident with ack_o.

Behaviour:
- Clock and reset: single clock; reset is asynchronous, active low.
- Reset values: state IDLE, wait counter 0, data_o 0, ack_o 0, err_o 0, hold_o 0 (forced low while nreset_i is low). RAM contents are not cleared by reset.
- req = !dm_CEn_i & (!dm_OEn_i | !dm_WEn_i).
- Write priority: if both OEn and WEn are low, the access is a write and is flagged as a strobe conflict.
- State machine, four states, one transition per clock:
  - IDLE: if req, capture addr_i, data_i, write flag and conflict flag; load cnt = WAIT_STATES. Go to BUSY if WAIT_STATES > 0, else to ACCESS. If no req, stay in IDLE.
  - BUSY: cnt decrements every cycle. When cnt == 1, go to ACCESS.
  - ACCESS: write → array[addr] <= data. Read → data_o <= array[addr]. Go to DONE.
  - DONE: ack_o = 1. err_o = 1 if conflict or addr ≥ DEPTH. Always go to IDLE.
- hold_o is combinational: 1 when (IDLE & req) or BUSY or ACCESS; 0 in DONE and in idle without req.
- Latency: hold_o is high for exactly WAIT_STATES + 2 cycles per access. The processor completes the instruction in the DONE cycle, when hold_o is low.
- Read data: data_o is valid from the DONE cycle and holds its value until the next read's ACCESS. Writes do not change data_o.
- Back-to-back accesses: strobes seen in the IDLE cycle after DONE start a new transaction. Strobes held continuously across DONE are therefore treated as a new access.
- Captured values are frozen: changes to addr_i, data_i or strobes after capture are ignored until IDLE.
- Out-of-range address (addr ≥ DEPTH): read returns 0, write is discarded, err_o pulses in DONE.
- Strobe conflict: write performed, err_o pulses in DONE.
- Reset mid-operation: immediate return to IDLE with hold_o low.
  - Reset before ACCESS: the pending write is discarded.
  - Reset in DONE: the write has already been committed.
- dm_CEn_i high means no transaction regardless of OEn/WEn.

Test Plan:
- WAIT_STATES=2, write 0xBEEF to addr 5, then read addr 5:
  - hold_o high for 4 cycles per access.
  - ack_o pulses once per access.
  - data_o = 0xBEEF in the read's DONE cycle; err_o stays 0.
- WAIT_STATES=0, read after writing 0x1234 to addr 0x3FF: hold_o high for 2 cycles, data_o = 0x1234.
- OEn and WEn both low, addr 7, data 0x00AA: the word is written, err_o pulses with ack_o, and a subsequent read of addr 7 returns 0x00AA.
- DEPTH=512, read addr 600: data_o = 0 and err_o = 1. Write 0x5555 to addr 600: all in-range words remain unchanged.
- Assert nreset_i low during BUSY of a write of 0x7777 to addr 3 (previously 0x0001): hold_o drops asynchronously, state returns to IDLE, and a later read of addr 3 returns 0x0001.
- Strobes held low across two consecutive transactions (addr 1 then 2): two ack_o pulses exactly WAIT_STATES + 3 cycles apart, with hold_o low for one cycle between them.

Source files
------------

// File: rtl/dm_wait_responder.sv
// dm_wait_responder: wait-state data-memory responder on CEn/OEn/WEn strobes.
// Ports: clock_i, nreset_i, addr_i, data_i, dm_*n_i in; hold_o, data_o, ack_o, err_o out.
module dm_wait_responder #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRRAM_WIDTH = 10,
  parameter int DEPTH         = 1024,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     clock_i,
  input  logic                     nreset_i,
  input  logic [ADDRRAM_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     dm_CEn_i,
  input  logic                     dm_OEn_i,
  input  logic                     dm_WEn_i,
  output logic                     hold_o,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     ack_o,
  output logic                     err_o
);

  localparam int AW = ADDRRAM_WIDTH;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LIM = DEPTH[AW:0];
  localparam logic [3:0] WS = WAIT_STATES[3:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic                  r_conf;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic          w_req;
  logic          w_oor;
  logic [IW-1:0] w_idx;

  assign w_req = !dm_CEn_i && (!dm_OEn_i || !dm_WEn_i);
  assign w_oor = ({1'b0, r_addr} >= LIM);
  assign w_idx = r_addr[IW-1:0];

  // Combinational so the core stalls in the very cycle the request appears.
  assign hold_o = nreset_i &&
                  ((r_state == S_IDLE && w_req) ||
                   r_state == S_BUSY ||
                   r_state == S_ACCESS);

  assign data_o = r_data;
  assign ack_o  = r_ack;
  assign err_o  = r_err;

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_conf  <= 1'b0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= addr_i;
            r_wdata <= data_i;
            // Write wins when both enables are low.
            r_we    <= !dm_WEn_i;
            r_conf  <= !dm_WEn_i && !dm_OEn_i;
            r_cnt   <= WS;
            r_state <= (WS != 4'd0) ? S_BUSY : S_ACCESS;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!r_we) r_data <= w_oor ? '0 : r_mem[w_idx];
          // Pulses are registered here so they appear in DONE.
          r_ack   <= 1'b1;
          r_err   <= r_conf || w_oor;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM is intentionally not reset; reset forces IDLE so no write escapes.
  always_ff @(posedge clock_i) begin
    if (r_state == S_ACCESS && r_we && !w_oor) r_mem[w_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_dm_wait_responder.sv
// tb_dm_wait_responder: table, random and directed checks of dm_wait_responder.
// Unit A: WAIT_STATES=2, DEPTH=512; unit B: WAIT_STATES=0, DEPTH=1024.
module tb_dm_wait_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  addr = '0;
  logic [15:0] din = '0;
  logic        ce = 1'b1;
  logic        oe = 1'b1;
  logic        we = 1'b1;

  logic        a_hold, a_ack, a_err;
  logic [15:0] a_dout;
  logic        b_hold, b_ack, b_err;
  logic [15:0] b_dout;

  bit          sel = 1'b0;
  logic        w_hold, w_ack, w_err;
  logic [15:0] w_dout;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem_m [512];
  bit          vld [512];
  bit          rd_known = 1'b1;
  logic [15:0] rd_last = 16'h0;

  typedef struct {
    bit          w;
    bit          r;
    logic [9:0]  a;
    logic [15:0] d;
    bit          xe;
    bit          cd;
    logic [15:0] xd;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  dm_wait_responder #(
    .DATA_WIDTH(16), .ADDRRAM_WIDTH(10), .DEPTH(512), .WAIT_STATES(2)
  ) dut_a (
    .clock_i(clk), .nreset_i(rst_n), .addr_i(addr), .data_i(din),
    .dm_CEn_i(ce), .dm_OEn_i(oe), .dm_WEn_i(we),
    .hold_o(a_hold), .data_o(a_dout), .ack_o(a_ack), .err_o(a_err)
  );

  dm_wait_responder #(
    .DATA_WIDTH(16), .ADDRRAM_WIDTH(10), .DEPTH(1024), .WAIT_STATES(0)
  ) dut_b (
    .clock_i(clk), .nreset_i(rst_n), .addr_i(addr), .data_i(din),
    .dm_CEn_i(ce), .dm_OEn_i(oe), .dm_WEn_i(we),
    .hold_o(b_hold), .data_o(b_dout), .ack_o(b_ack), .err_o(b_err)
  );

  assign w_hold = sel ? b_hold : a_hold;
  assign w_ack  = sel ? b_ack  : a_ack;
  assign w_err  = sel ? b_err  : a_err;
  assign w_dout = sel ? b_dout : a_dout;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Starts just after a negedge; ends just after a negedge.
  task automatic run(input string nm, input bit w, input bit r,
                     input logic [9:0] a, input logic [15:0] d,
                     input bit xe, input bit cd, input logic [15:0] xd);
    int ws;
    int hc;
    int n;
    ws = sel ? 0 : 2;
    addr = a; din = d; ce = 1'b0; oe = ~r; we = ~w;
    #1;
    hc = w_hold ? 1 : 0;
    @(posedge clk);
    @(negedge clk);
    ce = 1'b1; oe = 1'b1; we = 1'b1;
    addr = 10'($urandom); din = 16'($urandom);
    #1;
    n = 0;
    while (!w_ack && n < 40) begin
      if (w_hold) hc++;
      @(negedge clk);
      #1;
      n++;
    end
    chk({nm, " ack"}, 32'(w_ack), 32'd1);
    chk({nm, " hold_cycles"}, hc, ws + 2);
    chk({nm, " hold_in_done"}, 32'(w_hold), 32'd0);
    chk({nm, " err"}, 32'(w_err), 32'(xe));
    if (cd) chk({nm, " data"}, 32'(w_dout), 32'(xd));
    @(negedge clk);
    #1;
    chk({nm, " ack_pulse"}, 32'(w_ack), 32'd0);
  endtask

  task automatic model_upd(input bit w, input logic [9:0] a,
                           input logic [15:0] d);
    if (w) begin
      if (a < 10'd512) begin
        mem_m[a[8:0]] = d;
        vld[a[8:0]] = 1'b1;
      end
    end else if (a >= 10'd512) begin
      rd_known = 1'b1; rd_last = 16'h0;
    end else begin
      rd_known = vld[a[8:0]]; rd_last = mem_m[a[8:0]];
    end
  endtask

  task automatic model_run(input string nm, input bit w, input bit r,
                           input logic [9:0] a, input logic [15:0] d);
    bit xe;
    bit cd;
    logic [15:0] xd;
    xe = (w && r) || (a >= 10'd512);
    if (w) begin
      cd = rd_known; xd = rd_last;
    end else if (a >= 10'd512) begin
      cd = 1'b1; xd = 16'h0;
    end else begin
      cd = vld[a[8:0]]; xd = mem_m[a[8:0]];
    end
    run(nm, w, r, a, d, xe, cd, xd);
    model_upd(w, a, d);
  endtask

  initial begin
    int c;
    int ack_n;
    int ack_c [2];
    logic [15:0] ack_d [2];
    int lowh;
    bit quiet;
    int kind;
    logic [9:0] ra;

    tbl[0] = '{1, 0, 10'd5,   16'hBEEF, 0, 1, 16'h0000};
    tbl[1] = '{0, 1, 10'd5,   16'h0000, 0, 1, 16'hBEEF};
    tbl[2] = '{1, 1, 10'd7,   16'h00AA, 1, 1, 16'hBEEF};
    tbl[3] = '{0, 1, 10'd7,   16'h0000, 0, 1, 16'h00AA};
    tbl[4] = '{1, 0, 10'd88,  16'h1111, 0, 1, 16'h00AA};
    tbl[5] = '{0, 1, 10'd600, 16'h0000, 1, 1, 16'h0000};
    tbl[6] = '{1, 0, 10'd600, 16'h5555, 1, 1, 16'h0000};
    tbl[7] = '{0, 1, 10'd88,  16'h0000, 0, 1, 16'h1111};

    repeat (3) @(negedge clk);
    #1;
    chk("reset hold", 32'(a_hold), 32'd0);
    chk("reset ack", 32'(a_ack), 32'd0);
    chk("reset err", 32'(a_err), 32'd0);
    chk("reset dout", 32'(a_dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run($sformatf("vec%0d", i), tbl[i].w, tbl[i].r, tbl[i].a,
          tbl[i].d, tbl[i].xe, tbl[i].cd, tbl[i].xd);
      model_upd(tbl[i].w, tbl[i].a, tbl[i].d);
    end

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      ra = 10'($urandom_range(0, 767));
      model_run($sformatf("rnd%0d", i), kind >= 2, kind != 2, ra,
                16'($urandom));
    end

    model_run("rst_pre", 1'b1, 1'b0, 10'd3, 16'h0001);
    addr = 10'd3; din = 16'h7777; ce = 1'b0; oe = 1'b1; we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid hold", 32'(a_hold), 32'd0);
    chk("rst_mid dout", 32'(a_dout), 32'd0);
    ce = 1'b1; we = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_after hold", 32'(a_hold), 32'd0);
    rd_known = 1'b1; rd_last = 16'h0;
    model_run("rst_read3", 1'b0, 1'b1, 10'd3, 16'h0);

    model_run("b2b_pre1", 1'b1, 1'b0, 10'd1, 16'h0101);
    model_run("b2b_pre2", 1'b1, 1'b0, 10'd2, 16'h0202);
    addr = 10'd1; ce = 1'b0; oe = 1'b0; we = 1'b1;
    ack_n = 0; lowh = 0;
    ack_c[0] = 0; ack_c[1] = 0;
    ack_d[0] = '0; ack_d[1] = '0;
    for (c = 0; c < 30 && ack_n < 2; c++) begin
      #1;
      if (c == 1) addr = 10'd2;
      if (ack_n == 1 && c == ack_c[0] + 2) begin
        ce = 1'b1; oe = 1'b1;
      end
      if (a_ack) begin
        ack_c[ack_n] = c; ack_d[ack_n] = a_dout; ack_n++;
      end
      if (ack_n == 1 && !a_hold) lowh++;
      @(negedge clk);
    end
    ce = 1'b1; oe = 1'b1;
    chk("b2b acks", ack_n, 2);
    chk("b2b spacing", ack_c[1] - ack_c[0], 5);
    chk("b2b hold_low", lowh, 1);
    chk("b2b data1", 32'(ack_d[0]), 32'h0101);
    chk("b2b data2", 32'(ack_d[1]), 32'h0202);
    repeat (3) @(negedge clk);
    #1;
    rd_known = 1'b1; rd_last = 16'h0202;

    ce = 1'b1; oe = 1'b0; we = 1'b0; addr = 10'd4;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (a_hold || a_ack) quiet = 1'b0;
    end
    chk("ce_high quiet", 32'(quiet), 32'd1);
    oe = 1'b1; we = 1'b1;
    model_run("ce_high read5", 1'b0, 1'b1, 10'd5, 16'h0);

    sel = 1'b1;
    run("b_wr3ff", 1'b1, 1'b0, 10'h3FF, 16'h1234, 1'b0, 1'b0, 16'h0);
    run("b_rd3ff", 1'b0, 1'b1, 10'h3FF, 16'h0, 1'b0, 1'b1, 16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
